// File: rtl/ddr_axi_req_sched.sv
// Round-robin scheduler sharing one DDR3 command channel between NUM_REQ requesters,
// with periodic refresh insertion. Optional statistics counters: CR_DDR_SCHED_STATS_EN.
module ddr_axi_req_sched #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 28,
  parameter int LEN_W        = 8,
  parameter int ID_W         = 2,
  parameter int REF_INTERVAL = 7800,
  parameter int REF_CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic                      cmd_wr_o,
  output logic [ADDR_W-1:0]         cmd_addr_o,
  output logic [LEN_W-1:0]          cmd_len_o,
  output logic [ID_W-1:0]           cmd_id_o,
  input  logic                      cmd_done_i,
  output logic                      ref_req_o,
  input  logic                      ref_ack_i,
  output logic                      busy_o,
  output logic                      ref_overrun_o
`ifdef CR_DDR_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grant_cnt_o,
  output logic [15:0]               stat_ref_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_REFRESH
  } state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]     cmd_len_q, cmd_len_d;
  logic [ID_W-1:0]      cmd_id_q, cmd_id_d;
  logic [REF_CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic                 ref_pending_q, ref_pending_d;
  logic                 ref_overrun_q, ref_overrun_d;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [LEN_W-1:0]  len_arr  [NUM_REQ];

  logic            sel_found;
  logic [ID_W-1:0] sel_idx;
  logic [ID_W:0]   scan;
  logic            cmd_hs;
  logic            ref_done;
  logic            ref_expire;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    assign len_arr[g]  = req_len_i[g*LEN_W +: LEN_W];
  end

  assign cmd_valid_o   = (state_q == S_ISSUE);
  assign ref_req_o     = (state_q == S_REFRESH);
  assign busy_o        = (state_q != S_IDLE);
  assign cmd_hs        = cmd_valid_o & cmd_ready_i;
  assign ref_done      = ref_req_o & ref_ack_i;
  assign ref_expire    = (ref_cnt_q == '0);
  assign cmd_wr_o      = cmd_wr_q;
  assign cmd_addr_o    = cmd_addr_q;
  assign cmd_len_o     = cmd_len_q;
  assign cmd_id_o      = cmd_id_q;
  assign ref_overrun_o = ref_overrun_q;

  // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; the first valid requester wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
      if (!sel_found && req_valid_i[scan[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (cmd_hs) req_ready_o[cmd_id_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    cmd_id_d   = cmd_id_q;
    case (state_q)
      S_IDLE: begin
        if (ref_pending_q) begin
          state_d = S_REFRESH;
        end else if (sel_found) begin
          cmd_wr_d   = req_wr_i[sel_idx];
          cmd_addr_d = addr_arr[sel_idx];
          cmd_len_d  = len_arr[sel_idx];
          cmd_id_d   = sel_idx;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready_i) begin
          rr_ptr_d = (cmd_id_q == ID_W'(NUM_REQ-1)) ? '0 : cmd_id_q + ID_W'(1);
          state_d  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (cmd_done_i) state_d = S_IDLE;
      S_REFRESH:   if (ref_ack_i)  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // A new expiry coinciding with an ack is a fresh request, not an overrun.
  always_comb begin
    ref_cnt_d     = ref_expire ? REF_CNT_W'(REF_INTERVAL-1) : ref_cnt_q - REF_CNT_W'(1);
    ref_pending_d = ref_pending_q;
    ref_overrun_d = ref_overrun_q;
    if (ref_expire) begin
      ref_pending_d = 1'b1;
      if (ref_pending_q && !ref_done) ref_overrun_d = 1'b1;
    end else if (ref_done) begin
      ref_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      cmd_wr_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      cmd_id_q      <= '0;
      ref_cnt_q     <= REF_CNT_W'(REF_INTERVAL-1);
      ref_pending_q <= 1'b0;
      ref_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      cmd_id_q      <= cmd_id_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_overrun_q <= ref_overrun_d;
    end
  end

`ifdef CR_DDR_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_grant_q;
  logic [15:0]              stat_ref_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grant_q <= '0;
      stat_ref_q   <= '0;
    end else begin
      if (cmd_hs && stat_grant_q[cmd_id_q] != 16'hFFFF)
        stat_grant_q[cmd_id_q] <= stat_grant_q[cmd_id_q] + 16'd1;
      if (ref_done && stat_ref_q != 16'hFFFF)
        stat_ref_q <= stat_ref_q + 16'd1;
    end
  end

  assign stat_grant_cnt_o = stat_grant_q;
  assign stat_ref_cnt_o   = stat_ref_q;
`endif

endmodule

// File: tb/tb_ddr_axi_req_sched.sv
// Directed bench for ddr_axi_req_sched: cycle vector table plus long refresh/overrun sequences.
// Stats checks are compiled in when CR_DDR_SCHED_STATS_EN is defined.
module tb_ddr_axi_req_sched;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 28;
  localparam int LEN_W   = 8;
  localparam int ID_W    = 2;
  localparam int REF_INT = 64;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_wr;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [LEN_W-1:0]          cmd_len;
  logic [ID_W-1:0]           cmd_id;
  logic                      cmd_done;
  logic                      ref_req;
  logic                      ref_ack;
  logic                      busy;
  logic                      ref_overrun;
`ifdef CR_DDR_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0]     stat_grant_cnt;
  logic [15:0]               stat_ref_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  ddr_axi_req_sched #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W),
    .REF_INTERVAL(REF_INT), .REF_CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_wr_i(req_wr),
    .req_addr_i(req_addr),
    .req_len_i(req_len),
    .cmd_valid_o(cmd_valid),
    .cmd_ready_i(cmd_ready),
    .cmd_wr_o(cmd_wr),
    .cmd_addr_o(cmd_addr),
    .cmd_len_o(cmd_len),
    .cmd_id_o(cmd_id),
    .cmd_done_i(cmd_done),
    .ref_req_o(ref_req),
    .ref_ack_i(ref_ack),
    .busy_o(busy),
`ifdef CR_DDR_SCHED_STATS_EN
    .stat_grant_cnt_o(stat_grant_cnt),
    .stat_ref_cnt_o(stat_ref_cnt),
`endif
    .ref_overrun_o(ref_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] valid;
    logic       rdy;
    logic       done;
    logic       chk;
    logic [3:0] e_ready;
    logic       e_cvalid;
    logic [1:0] e_id;
    logic       pay;     // 1: payload of e_id expected, 0: reset (zero) payload
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic rdy, input logic done,
                     input logic chk, input logic [3:0] e_ready, input logic e_cvalid,
                     input logic [1:0] e_id, input logic pay, input logic e_busy);
    vec_t t;
    t.rst_n = r; t.valid = v; t.rdy = rdy; t.done = done; t.chk = chk;
    t.e_ready = e_ready; t.e_cvalid = e_cvalid; t.e_id = e_id; t.pay = pay; t.e_busy = e_busy;
    vecs.push_back(t);
  endtask

  // Drive on the falling edge; outputs are then sampled 1 time unit later.
  task automatic step(input logic r, input logic [3:0] v, input logic rdy,
                      input logic done, input logic ack);
    @(negedge clk);
    rst_n = r; req_valid = v; cmd_ready = rdy; cmd_done = done; ref_ack = ack;
    #1;
  endtask

  initial begin
    logic [27:0] e_addr;
    logic [7:0]  e_len;
    logic        e_wr;
    logic        e_ref;

    rst_n = 1'b0; req_valid = '0; cmd_ready = 1'b0; cmd_done = 1'b0; ref_ack = 1'b0;
    req_addr = {28'h1236000, 28'h1234000, 28'h1232000, 28'h1230000};
    req_len  = {8'd8, 8'd7, 8'd6, 8'd5};
    req_wr   = 4'b0110;

    // Round robin with all requesters valid: ids 0,1,2,3,0, one-hot single-cycle ready pulses.
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b0001, 1, 0, 1, 1);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 0, 1, 1);
    add(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 0, 1, 1);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 0, 1, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b0010, 1, 1, 1, 1);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 1, 1, 1);
    add(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 1, 1, 1);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 1, 1, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b0100, 1, 2, 1, 1);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 2, 1, 1);
    add(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 2, 1, 1);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 2, 1, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b1000, 1, 3, 1, 1);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 3, 1, 1);
    add(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 3, 1, 1);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 3, 1, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b0001, 1, 0, 1, 1);
    // Backpressure on requester 2, done ignored in ISSUE, then pointer wrap 3 -> 0.
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b0100, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b0100, 0, 0, 1, 4'b0000, 1, 2, 1, 1);
    add(1, 4'b0100, 0, 0, 1, 4'b0000, 1, 2, 1, 1);
    add(1, 4'b0100, 0, 1, 1, 4'b0000, 1, 2, 1, 1);
    add(1, 4'b0100, 0, 0, 1, 4'b0000, 1, 2, 1, 1);
    add(1, 4'b0100, 0, 0, 1, 4'b0000, 1, 2, 1, 1);
    add(1, 4'b0100, 1, 0, 1, 4'b0100, 1, 2, 1, 1);
    add(1, 4'b0000, 1, 0, 1, 4'b0000, 0, 2, 1, 1);
    add(1, 4'b0000, 1, 1, 1, 4'b0000, 0, 2, 1, 1);
    add(1, 4'b0011, 1, 0, 1, 4'b0000, 0, 2, 1, 0);
    add(1, 4'b0011, 1, 0, 1, 4'b0001, 1, 0, 1, 1);
    add(1, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 1, 1);
    add(1, 4'b0000, 1, 0, 1, 4'b0000, 0, 0, 1, 0);
    // Reset during WAIT_DONE, stale done afterwards, arbitration restarts at requester 0.
    add(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b0010, 1, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b0010, 1, 0, 1, 4'b0010, 1, 1, 1, 1);
    add(0, 4'b0000, 1, 0, 1, 4'b0000, 0, 1, 1, 1);
    add(1, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'b1111, 1, 0, 1, 4'b0001, 1, 0, 1, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].valid, vecs[i].rdy, vecs[i].done, 1'b0);
      if (vecs[i].chk) begin
        e_addr = vecs[i].pay ? 28'h1230000 + (28'(vecs[i].e_id) << 13) : 28'h0;
        e_len  = vecs[i].pay ? 8'd5 + 8'(vecs[i].e_id) : 8'h0;
        e_wr   = vecs[i].pay ? req_wr[vecs[i].e_id] : 1'b0;
        check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
        check($sformatf("v%0d cmd_valid", i), 32'(cmd_valid), 32'(vecs[i].e_cvalid));
        check($sformatf("v%0d cmd_id", i),    32'(cmd_id),    32'(vecs[i].e_id));
        check($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].e_busy));
        check($sformatf("v%0d cmd_addr", i),  32'(cmd_addr),  32'(e_addr));
        check($sformatf("v%0d cmd_len", i),   32'(cmd_len),   32'(e_len));
        check($sformatf("v%0d cmd_wr", i),    32'(cmd_wr),    32'(e_wr));
        check($sformatf("v%0d ref_req", i),   32'(ref_req),   32'd0);
      end
    end

    // Refresh priority with requester 1 streaming (3-cycle command period).
    step(0, 4'b0000, 0, 0, 0);
    for (int k = 0; k <= 66; k++) begin
      step(1, 4'b0010, 1, 1, 0);
      check($sformatf("rp c%0d ref_req", k),   32'(ref_req),   32'd0);
      check($sformatf("rp c%0d cmd_valid", k), 32'(cmd_valid), 32'(k % 3 == 1));
    end
    for (int k = 67; k <= 72; k++) begin
      step(1, 4'b0010, 1, 1, k == 72);
      check($sformatf("rp c%0d ref_req", k),   32'(ref_req),   32'd1);
      check($sformatf("rp c%0d cmd_valid", k), 32'(cmd_valid), 32'd0);
      check($sformatf("rp c%0d req_ready", k), 32'(req_ready), 32'd0);
    end
    step(1, 4'b0010, 1, 1, 0);
    check("rp c73 ref_req", 32'(ref_req), 32'd0);
    check("rp c73 busy",    32'(busy),    32'd0);
    step(1, 4'b0010, 1, 1, 0);
    check("rp c74 cmd_valid", 32'(cmd_valid), 32'd1);
    check("rp c74 cmd_id",    32'(cmd_id),    32'd1);
    check("rp overrun",       32'(ref_overrun), 32'd0);

    // Ack on an expiry cycle re-requests without overrun; a later withheld ack overruns.
    step(0, 4'b0000, 0, 0, 0);
    for (int k = 0; k <= 196; k++) begin
      step(1, 4'b0000, 0, 0, (k == 127) || (k == 193));
      e_ref = (k >= 65) && (k <= 193) && (k != 128);
      check($sformatf("ov c%0d ref_req", k),     32'(ref_req),     32'(e_ref));
      check($sformatf("ov c%0d busy", k),        32'(busy),        32'(e_ref));
      check($sformatf("ov c%0d ref_overrun", k), 32'(ref_overrun), 32'(k >= 192));
    end
    step(0, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0);
    check("ov reset ref_overrun", 32'(ref_overrun), 32'd0);
    check("ov reset ref_req",     32'(ref_req),     32'd0);

`ifdef CR_DDR_SCHED_STATS_EN
    // Ten grants to requester 3 followed by two acknowledged refreshes.
    step(0, 4'b0000, 0, 0, 0);
    for (int k = 0; k <= 135; k++) step(1, (k < 30) ? 4'b1000 : 4'b0000, 1, 1, 1);
    check("stat grant3", 32'(stat_grant_cnt[63:48]), 32'd10);
    check("stat grant2", 32'(stat_grant_cnt[47:32]), 32'd0);
    check("stat grant1", 32'(stat_grant_cnt[31:16]), 32'd0);
    check("stat grant0", 32'(stat_grant_cnt[15:0]),  32'd0);
    check("stat ref",    32'(stat_ref_cnt),          32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
